// File: rtl/xeng_acc_drain.sv
// Drains the X-engine accumulator stream: tags each word with its baseline index and
// buffers it in a first-word-fall-through FIFO (block RAM plus head register).
module xeng_acc_drain #(
    parameter int ACC_BITS        = 14,
    parameter int N_BL_BITS       = 4,
    parameter int FIFO_DEPTH_BITS = 5,
    parameter int FRAME_CNT_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sync,
    input  logic                         valid_in,
    input  logic [2*ACC_BITS-1:0]        acc_in,
    output logic [2*ACC_BITS-1:0]        dout,
    output logic [N_BL_BITS-1:0]         dout_bl,
    output logic                         dout_last,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [FIFO_DEPTH_BITS:0]     fifo_count,
    output logic                         overflow,
    output logic [FRAME_CNT_BITS-1:0]    frame_cnt
);

    localparam int W       = 2 * ACC_BITS;
    localparam int ENTRY_W = W + N_BL_BITS;
    localparam int DEPTH_N = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] DEPTH   = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    localparam logic [N_BL_BITS-1:0]     BL_LAST = '1;

    logic [N_BL_BITS-1:0]       bl_ctr_reg;
    logic [N_BL_BITS-1:0]       bl_ctr_next;
    logic [N_BL_BITS-1:0]       tag;
    logic                       push;
    logic                       pop;
    logic                       load;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [FIFO_DEPTH_BITS:0]   ram_cnt_reg;
    logic [FIFO_DEPTH_BITS:0]   ram_cnt_next;
    logic [FIFO_DEPTH_BITS:0]   count_reg;
    logic [FIFO_DEPTH_BITS:0]   count_next;
    logic                       head_valid_reg;
    logic                       head_valid_next;
    logic [ENTRY_W-1:0]         head_reg;
    logic                       overflow_reg;
    logic [FRAME_CNT_BITS-1:0]  frame_cnt_reg;
    logic [ENTRY_W-1:0]         ram [DEPTH_N];

    // sync forces the current word's tag to 0, so the counter resumes from 1 after it
    assign tag  = sync ? '0 : bl_ctr_reg;
    assign push = valid_in && (count_reg < DEPTH);
    assign pop  = head_valid_reg && dout_ready;
    // The head register refills from RAM whenever it is empty or being consumed
    assign load = (ram_cnt_reg != '0) && (!head_valid_reg || pop);

    always_comb begin
        bl_ctr_next = bl_ctr_reg;
        if (valid_in) begin
            bl_ctr_next = tag + 1'b1;
        end else if (sync) begin
            bl_ctr_next = '0;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        ram_cnt_next = ram_cnt_reg;
        case ({push, load})
            2'b10:   ram_cnt_next = ram_cnt_reg + 1'b1;
            2'b01:   ram_cnt_next = ram_cnt_reg - 1'b1;
            default: ram_cnt_next = ram_cnt_reg;
        endcase
    end

    always_comb begin
        head_valid_next = head_valid_reg;
        if (load) begin
            head_valid_next = 1'b1;
        end else if (pop) begin
            head_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ram[wr_ptr_reg] <= {tag, acc_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bl_ctr_reg     <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            ram_cnt_reg    <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
            head_reg       <= '0;
            overflow_reg   <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            bl_ctr_reg     <= bl_ctr_next;
            ram_cnt_reg    <= ram_cnt_next;
            count_reg      <= count_next;
            head_valid_reg <= head_valid_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load) begin
                head_reg   <= ram[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (valid_in && !push) begin
                overflow_reg <= 1'b1;
            end
            // Dump completion is counted on the tag, stored or dropped alike
            if (valid_in && (tag == BL_LAST)) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign dout       = head_reg[W-1:0];
    assign dout_bl    = head_reg[ENTRY_W-1:W];
    assign dout_last  = (dout_bl == BL_LAST);
    assign dout_valid = head_valid_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: doc/xeng_acc_drain.md
Name: xeng_acc_drain

Overview:
- Sits directly downstream of the last cmac in the X-engine antenna tap chain.
- Consumes the accumulator shift-register stream {real, imag} qualified by valid_in.
- Tags each accumulated word with its baseline index and a frame-last flag, then buffers it in a first-word-fall-through FIFO.
- Presents the FIFO contents on a valid/ready output towards the packetiser; FIFO overflow is flagged, never stalls the chain.

Parameters:
- ACC_BITS, 14: bits per real/imag part of the accumulator word; must equal ACC_BITS_OUT of the feeding cmac.
- N_BL_BITS, 4: baselines per dump = 2^N_BL_BITS; the baseline counter width.
- FIFO_DEPTH_BITS, 5: FIFO depth = 2^FIFO_DEPTH_BITS entries.
- FRAME_CNT_BITS, 16: width of the completed-dump counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sync  input  1  frame-alignment pulse, same sync as fed to the cmac chain, delayed externally to align with the first valid word of a dump.
- valid_in  input  1  acc_in qualifier from the tail cmac valid_out.
- acc_in  input  2*ACC_BITS  {real[2*ACC_BITS-1:ACC_BITS], imag[ACC_BITS-1:0]}.
- dout  output  2*ACC_BITS  head-of-FIFO word, same packing as acc_in.
- dout_bl  output  N_BL_BITS  baseline index of dout.
- dout_last  output  1  high when dout_bl == 2^N_BL_BITS-1.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout this cycle.
- fifo_count  output  FIFO_DEPTH_BITS+1  entries currently held.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.
- frame_cnt  output  FRAME_CNT_BITS  completed dumps, wraps modulo 2^FRAME_CNT_BITS.

Behaviour:
- Reset: dout, dout_bl, dout_last, dout_valid, fifo_count, overflow and frame_cnt are all 0. The baseline counter is 0 and the FIFO is empty.
- Reset mid-dump: the FIFO is flushed and partial-dump tags are discarded. The first valid_in after rst deasserts is tagged baseline 0.
- Baseline counter bl_ctr advances by 1 on every valid_in cycle, whether or not the word is stored. It wraps from 2^N_BL_BITS-1 to 0.
- sync: the next bl_ctr value is forced to 0.
  - If sync and valid_in coincide, the current word is tagged 0 and bl_ctr becomes 1.
  - sync without valid_in sets bl_ctr to 0.
- Tag stored with each word: {bl_ctr (or 0 when sync), last = tag==2^N_BL_BITS-1}.
- Push: occurs when valid_in=1 and the registered fifo_count < 2^FIFO_DEPTH_BITS.
- Full: if valid_in=1 and the FIFO is full, the word is dropped and overflow is set to 1. overflow stays 1 until rst. This holds even if a pop happens in the same cycle, because the full decision uses the registered count.
- Pop: occurs when dout_valid=1 and dout_ready=1. dout_ready while empty has no effect.
- Push and pop in the same cycle with 0 < count < full: fifo_count is unchanged and both take effect.
- Latency: a word pushed at edge t is visible on dout/dout_bl/dout_last with dout_valid=1 after edge t+1 when the FIFO was empty. Otherwise it is visible once it reaches the head.
- Outputs are stable while dout_valid=1 and dout_ready=0.
- frame_cnt increments by 1 on each valid_in cycle whose tag is 2^N_BL_BITS-1, whether stored or dropped.
- No arithmetic is applied: acc_in bits pass through unchanged, with real and imag kept in place.
- Storage: dual-port RAM with read-ahead register. Read and write pointers are FIFO_DEPTH_BITS wide and wrap naturally.

Test Plan:
- Reset, then 16 consecutive valid_in words (N_BL_BITS=4) with sync on the first and dout_ready=1 -> dout_bl goes 0..15 in order, dout_last only with bl 15, frame_cnt=1, dout equals acc_in one cycle later, overflow=0.
- dout_ready=0, 40 valid words, depth 32 -> fifo_count=32, overflow=1. Then dout_ready=1 drains exactly 32 words tagged bl 0..15,0..15. frame_cnt=2 (words 32..39 advance bl to 8; drops do not stall).
- Mid-dump sync after 5 words -> 6th word tagged bl 0, dout_last next asserted 15 words later.
- Full FIFO with push and pop in the same cycle -> pushed word dropped, overflow=1, fifo_count=31.
- Non-full FIFO, simultaneous push/pop at count 7 for 10 cycles -> fifo_count stays 7 and output order is preserved.
- rst asserted with 9 entries and bl_ctr=9 -> dout_valid=0, fifo_count=0, overflow=0, frame_cnt=0; next valid_in tagged bl 0.
